// File: rtl/gcd_engine.sv
// Iterative GCD engine (subtractive Euclid or binary Stein, chosen by ALGO) with a valid/ready operand and result handshake.
// Latency: one capture edge plus one CALC edge per step; a zero operand finishes on the capture edge with cycles=0.
// Backpressure: in_ready only in IDLE; the result is held stable in DONE until out_ready, then one IDLE cycle follows.
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int ALGO  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] cycles,
    output logic             err
);

    // k counts common factors of two; WIDTH halvings at most, so it never overflows
    localparam int K_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [K_W-1:0]   shiftK;
    logic [CNT_W-1:0] iterCnt;

    logic [CNT_W-1:0] cntNext;
    logic [WIDTH-1:0] diffAB;
    logic [WIDTH-1:0] diffBA;
    logic             aGtB;
    logic             aEqB;
    logic             aEven;
    logic             bEven;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Step datapath: saturating count and both subtraction directions; only the one with the larger minuend is used
    always_comb begin
        cntNext = iterCnt;
        if (iterCnt != '1) begin
            cntNext = iterCnt + CNT_W'(1);
        end
        diffAB = regA - regB;
        diffBA = regB - regA;
        aGtB   = (regA > regB);
        aEqB   = (regA == regB);
        aEven  = ~regA[0];
        bEven  = ~regB[0];
    end

    // Control FSM and operand registers; outputs are registered and only change on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            regA    <= '0;
            regB    <= '0;
            shiftK  <= '0;
            iterCnt <= '0;
            result  <= '0;
            cycles  <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        regA    <= a_in;
                        regB    <= b_in;
                        shiftK  <= '0;
                        iterCnt <= '0;
                        if ((a_in == '0) || (b_in == '0)) begin
                            // gcd(x,0)=x needs no iteration; both zero is flagged as an error
                            result <= a_in | b_in;
                            cycles <= '0;
                            err    <= (a_in == '0) && (b_in == '0);
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end

                CALC: begin
                    iterCnt <= cntNext;
                    if (ALGO == 0) begin
                        if (aEqB) begin
                            result <= regA;
                            cycles <= cntNext;
                            err    <= 1'b0;
                            state  <= DONE;
                        end else if (aGtB) begin
                            regA <= diffAB;
                        end else begin
                            regB <= diffBA;
                        end
                    end else begin
                        if (aEqB) begin
                            // restore the common power of two removed earlier
                            result <= regA << shiftK;
                            cycles <= cntNext;
                            err    <= 1'b0;
                            state  <= DONE;
                        end else if (aEven && bEven) begin
                            regA   <= regA >> 1;
                            regB   <= regB >> 1;
                            shiftK <= shiftK + K_W'(1);
                        end else if (aEven) begin
                            regA <= regA >> 1;
                        end else if (bEven) begin
                            regB <= regB >> 1;
                        end else if (aGtB) begin
                            // difference of two odd numbers is even, so halve it in the same step
                            regA <= diffAB >> 1;
                        end else begin
                            regB <= diffBA >> 1;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and randomised bench for gcd_engine across five parameterisations sharing one clock and reset.
// Instances: 0 W16/Euclid, 1 W16/Stein, 2 W16/Euclid/CNT_W=8, 3 W8/Euclid, 4 W8/Stein.
// Each task drives one scenario and compares inline against hand-computed or reference-model values.
module tb_gcd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid  [5];
    logic        outReady [5];
    logic [15:0] aIn      [5];
    logic [15:0] bIn      [5];
    logic        inRdy    [5];
    logic        outVld   [5];
    logic        errO     [5];
    logic [15:0] res16    [3];
    logic [7:0]  res8     [2];
    logic [15:0] cycW     [4];
    logic [7:0]  cyc2;

    int checks = 0;
    int errors = 0;
    int hsCnt [5] = '{default: 0};

    always #5 clk = ~clk;

    gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inRdy[0]),
        .a_in(aIn[0]), .b_in(bIn[0]), .out_valid(outVld[0]), .out_ready(outReady[0]),
        .result(res16[0]), .cycles(cycW[0]), .err(errO[0]));
    gcd_engine #(.WIDTH(16), .ALGO(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inRdy[1]),
        .a_in(aIn[1]), .b_in(bIn[1]), .out_valid(outVld[1]), .out_ready(outReady[1]),
        .result(res16[1]), .cycles(cycW[1]), .err(errO[1]));
    gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inRdy[2]),
        .a_in(aIn[2]), .b_in(bIn[2]), .out_valid(outVld[2]), .out_ready(outReady[2]),
        .result(res16[2]), .cycles(cyc2), .err(errO[2]));
    gcd_engine #(.WIDTH(8), .ALGO(0), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .in_valid(inValid[3]), .in_ready(inRdy[3]),
        .a_in(aIn[3][7:0]), .b_in(bIn[3][7:0]), .out_valid(outVld[3]), .out_ready(outReady[3]),
        .result(res8[0]), .cycles(cycW[2]), .err(errO[3]));
    gcd_engine #(.WIDTH(8), .ALGO(1), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .in_valid(inValid[4]), .in_ready(inRdy[4]),
        .a_in(aIn[4][7:0]), .b_in(bIn[4][7:0]), .out_valid(outVld[4]), .out_ready(outReady[4]),
        .result(res8[1]), .cycles(cycW[3]), .err(errO[4]));

    // Count result handshakes per instance to detect lost or duplicated results
    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (outVld[i] && outReady[i]) hsCnt[i] <= hsCnt[i] + 1;
        end
    end

    function automatic logic [15:0] getRes(input int i);
        case (i)
            0: return res16[0];
            1: return res16[1];
            2: return res16[2];
            3: return {8'h00, res8[0]};
            default: return {8'h00, res8[1]};
        endcase
    endfunction

    function automatic logic [15:0] getCyc(input int i);
        case (i)
            0: return cycW[0];
            1: return cycW[1];
            2: return {8'h00, cyc2};
            3: return cycW[2];
            default: return cycW[3];
        endcase
    endfunction

    function automatic logic [15:0] refGcd(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p, q, t;
        p = x; q = y;
        while (q != 16'd0) begin
            t = p % q; p = q; q = t;
        end
        return p;
    endfunction

    // Drives one operation on instance i and reports what it observed; no comparisons here.
    // lat counts edges after the capture edge until out_valid is seen.
    task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input bit junk, input int limit,
                          output logic [15:0] r, output logic [15:0] c, output logic e,
                          output int lat, output bit tmo, output bit stable);
        tmo = 1'b0; stable = 1'b1; lat = 0;
        @(negedge clk);
        aIn[i] = a; bIn[i] = b; inValid[i] = 1'b1; outReady[i] = (hold == 0);
        @(posedge clk); #1;
        if (junk) begin
            aIn[i] = ~a; bIn[i] = a ^ 16'h5a5a;
        end else begin
            inValid[i] = 1'b0;
        end
        while (!outVld[i] && lat < limit) begin
            if (inRdy[i] !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        inValid[i] = 1'b0;
        r = getRes(i); c = getCyc(i); e = errO[i];
        if (!outVld[i]) begin
            tmo = 1'b1; outReady[i] = 1'b0;
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (getRes(i) !== r || getCyc(i) !== c || errO[i] !== e ||
                outVld[i] !== 1'b1 || inRdy[i] !== 1'b0) stable = 1'b0;
        end
        outReady[i] = 1'b1;
        @(posedge clk); #1;
        outReady[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            inValid[i] = 1'b0; outReady[i] = 1'b0; aIn[i] = 16'd0; bIn[i] = 16'd0;
        end
        // operands offered during reset must be ignored
        inValid[0] = 1'b1; aIn[0] = 16'd5; bIn[0] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inRdy[i] !== 1'b1) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 1", i, inRdy[i]); end
            checks++;
            if (outVld[i] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", i, outVld[i]); end
        end
        checks++;
        if (getRes(0) !== 16'd0) begin errors++; $display("FAIL reset_result got %0d want 0", getRes(0)); end
        checks++;
        if (getCyc(0) !== 16'd0) begin errors++; $display("FAIL reset_cycles got %0d want 0", getCyc(0)); end
        checks++;
        if (errO[0] !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", errO[0]); end
        inValid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_euclid;
        int ta [5] = '{48, 35, 17, 9, 7};
        int tb [5] = '{18, 14, 5, 9, 21};
        int tr [5] = '{6, 7, 1, 9, 7};
        int tc [5] = '{5, 4, 7, 1, 3};
        logic [15:0] r, c; logic e; int lat; bit tmo, st;
        for (int n = 0; n < 5; n++) begin
            run_op(0, 16'(ta[n]), 16'(tb[n]), 0, 1'b0, 1000, r, c, e, lat, tmo, st);
            checks++;
            if (tmo) begin errors++; $display("FAIL euclid_timeout a=%0d b=%0d", ta[n], tb[n]); end
            checks++;
            if (r !== 16'(tr[n])) begin errors++; $display("FAIL euclid_result a=%0d b=%0d got %0d want %0d", ta[n], tb[n], r, tr[n]); end
            checks++;
            if (c !== 16'(tc[n])) begin errors++; $display("FAIL euclid_cycles a=%0d b=%0d got %0d want %0d", ta[n], tb[n], c, tc[n]); end
            checks++;
            if (lat != tc[n]) begin errors++; $display("FAIL euclid_latency a=%0d b=%0d got %0d want %0d", ta[n], tb[n], lat, tc[n]); end
            checks++;
            if (e !== 1'b0) begin errors++; $display("FAIL euclid_err a=%0d b=%0d got %b want 0", ta[n], tb[n], e); end
        end
    endtask

    task automatic test_stein;
        int ta [5] = '{48, 9, 8, 15, 64};
        int tb [5] = '{18, 9, 12, 10, 96};
        int tr [5] = '{6, 9, 4, 5, 32};
        int tc [5] = '{6, 1, 5, 3, 8};
        logic [15:0] r, c; logic e; int lat; bit tmo, st;
        for (int n = 0; n < 5; n++) begin
            run_op(1, 16'(ta[n]), 16'(tb[n]), 0, 1'b0, 1000, r, c, e, lat, tmo, st);
            checks++;
            if (tmo) begin errors++; $display("FAIL stein_timeout a=%0d b=%0d", ta[n], tb[n]); end
            checks++;
            if (r !== 16'(tr[n])) begin errors++; $display("FAIL stein_result a=%0d b=%0d got %0d want %0d", ta[n], tb[n], r, tr[n]); end
            checks++;
            if (c !== 16'(tc[n])) begin errors++; $display("FAIL stein_cycles a=%0d b=%0d got %0d want %0d", ta[n], tb[n], c, tc[n]); end
            checks++;
            if (lat != tc[n]) begin errors++; $display("FAIL stein_latency a=%0d b=%0d got %0d want %0d", ta[n], tb[n], lat, tc[n]); end
        end
    endtask

    task automatic test_zero;
        int ta [3] = '{0, 0, 5};
        int tb [3] = '{7, 0, 0};
        int tr [3] = '{7, 0, 5};
        logic te [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] r, c; logic e; int lat; bit tmo, st;
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 3; n++) begin
                run_op(i, 16'(ta[n]), 16'(tb[n]), 0, 1'b0, 100, r, c, e, lat, tmo, st);
                checks++;
                if (r !== 16'(tr[n]) || c !== 16'd0 || e !== te[n] || lat != 0 || tmo)
                begin errors++; $display("FAIL zero[%0d] a=%0d b=%0d got r=%0d c=%0d e=%b lat=%0d want r=%0d c=0 e=%b lat=0", i, ta[n], tb[n], r, c, e, lat, tr[n], te[n]); end
            end
        end
        // err must clear on the next non-zero operation
        run_op(1, 16'd6, 16'd4, 0, 1'b0, 100, r, c, e, lat, tmo, st);
        checks++;
        if (r !== 16'd2 || c !== 16'd4 || e !== 1'b0) begin errors++; $display("FAIL zero_followup got r=%0d c=%0d e=%b want r=2 c=4 e=0", r, c, e); end
    endtask

    task automatic test_saturation;
        logic [15:0] r, c; logic e; int lat; bit tmo, st;
        run_op(2, 16'd65535, 16'd1, 10, 1'b0, 70000, r, c, e, lat, tmo, st);
        checks++;
        if (tmo) begin errors++; $display("FAIL sat_timeout lat=%0d", lat); end
        checks++;
        if (r !== 16'd1) begin errors++; $display("FAIL sat_result got %0d want 1", r); end
        checks++;
        if (c !== 16'd255) begin errors++; $display("FAIL sat_cycles got %0d want 255", c); end
        checks++;
        if (lat != 65535) begin errors++; $display("FAIL sat_latency got %0d want 65535", lat); end
        checks++;
        if (!st) begin errors++; $display("FAIL sat_hold_stable got unstable want stable"); end
        checks++;
        if (inRdy[2] !== 1'b1 || outVld[2] !== 1'b0) begin errors++; $display("FAIL sat_after_hs got in_ready=%b out_valid=%b want 1 0", inRdy[2], outVld[2]); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] r, c; logic e; int lat; bit tmo, st;
        // in_valid stays high with changing operands during CALC; those must be ignored
        run_op(1, 16'd48, 16'd18, 0, 1'b1, 1000, r, c, e, lat, tmo, st);
        checks++;
        if (r !== 16'd6 || c !== 16'd6 || tmo || !st) begin errors++; $display("FAIL b2b_first got r=%0d c=%0d tmo=%0d st=%0d want r=6 c=6 tmo=0 st=1", r, c, tmo, st); end
        checks++;
        if (inRdy[1] !== 1'b1 || outVld[1] !== 1'b0) begin errors++; $display("FAIL b2b_idle got in_ready=%b out_valid=%b want 1 0", inRdy[1], outVld[1]); end
        run_op(1, 16'd8, 16'd12, 2, 1'b1, 1000, r, c, e, lat, tmo, st);
        checks++;
        if (r !== 16'd4 || c !== 16'd5 || tmo || !st) begin errors++; $display("FAIL b2b_second got r=%0d c=%0d tmo=%0d st=%0d want r=4 c=5 tmo=0 st=1", r, c, tmo, st); end
    endtask

    task automatic test_reset_abort;
        logic [15:0] r, c; logic e; int lat; bit tmo, st;
        int hs0;
        hs0 = hsCnt[0];
        @(negedge clk);
        aIn[0] = 16'd1000; bIn[0] = 16'd3; inValid[0] = 1'b1; outReady[0] = 1'b1;
        @(posedge clk); #1;
        inValid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (outVld[0] !== 1'b0 || inRdy[0] !== 1'b1) begin errors++; $display("FAIL abort_immediate got out_valid=%b in_ready=%b want 0 1", outVld[0], inRdy[0]); end
        @(negedge clk);
        rst = 1'b0;
        outReady[0] = 1'b0;
        run_op(0, 16'd12, 16'd8, 0, 1'b0, 1000, r, c, e, lat, tmo, st);
        checks++;
        if (r !== 16'd4 || c !== 16'd3 || tmo) begin errors++; $display("FAIL abort_next got r=%0d c=%0d tmo=%0d want r=4 c=3 tmo=0", r, c, tmo); end
        checks++;
        if (hsCnt[0] != hs0 + 1) begin errors++; $display("FAIL abort_handshakes got %0d want %0d", hsCnt[0] - hs0, 1); end
    endtask

    task automatic test_random;
        logic [15:0] r, c, a, b, g; logic e; int lat; bit tmo, st;
        int hsBase, nOps;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) continue;
            hsBase = hsCnt[i];
            nOps = 20;
            for (int n = 0; n < nOps; n++) begin
                if (i >= 3) begin
                    a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
                end else if (i == 0) begin
                    g = 16'($urandom_range(1, 200));
                    a = g * 16'($urandom_range(1, 40)); b = g * 16'($urandom_range(1, 40));
                end else begin
                    a = 16'($urandom_range(1, 65535)); b = 16'($urandom_range(1, 65535));
                end
                run_op(i, a, b, int'($urandom_range(0, 3)), 1'b0, 2000, r, c, e, lat, tmo, st);
                checks++;
                if (tmo || r !== refGcd(a, b) || e !== (a == 16'd0 && b == 16'd0) || !st)
                begin errors++; $display("FAIL rand[%0d] a=%0d b=%0d got r=%0d e=%b tmo=%0d st=%0d want r=%0d", i, a, b, r, e, tmo, st, refGcd(a, b)); end
            end
            checks++;
            if (hsCnt[i] - hsBase != nOps) begin errors++; $display("FAIL rand_handshakes[%0d] got %0d want %0d", i, hsCnt[i] - hsBase, nOps); end
        end
    endtask

    initial begin
        test_reset;
        test_euclid;
        test_stein;
        test_zero;
        test_back_to_back;
        test_reset_abort;
        test_random;
        test_saturation;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
